// File: rtl/riscv_definitions.sv
// Definitions shared by the memory-port arbiter: read-response owner encoding
// and the default DM streak limit.
package riscv_definitions;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } mem_owner_t;

  localparam int unsigned DEF_MAX_DM_STREAK = 4;
endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive DM wins while IF waits; at_max hands the
// next slot to IF.
module arb_streak_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (clr)                        cnt <= '0;
    else if (inc && (cnt != W'(MAX)))    cnt <= cnt + 1'b1;
  end

  assign at_max = (cnt == W'(MAX));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// data-memory stage; one access per cycle, read data routed back by owner tag.
module mem_port_arbiter
  import riscv_definitions::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH/8-1:0]   i_if_rd_en,
  input  logic [ADDR_WIDTH-1:0]     i_if_addr,
  input  logic                      i_if_flush,
  output logic                      o_if_gnt,
  output logic                      o_if_rvalid,
  output logic [DATA_WIDTH-1:0]     o_if_rdata,
  output logic                      o_if_stall,
  input  logic [DATA_WIDTH/8-1:0]   i_dm_rd_en,
  input  logic [DATA_WIDTH/8-1:0]   i_dm_wr_en,
  input  logic [ADDR_WIDTH-1:0]     i_dm_addr,
  input  logic [DATA_WIDTH-1:0]     i_dm_wdata,
  output logic                      o_dm_gnt,
  output logic                      o_dm_rvalid,
  output logic [DATA_WIDTH-1:0]     o_dm_rdata,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  output logic [DATA_WIDTH/8-1:0]   o_mem_rd_en,
  output logic [DATA_WIDTH/8-1:0]   o_mem_wr_en,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);
  logic if_req, dm_req, dm_wr, if_win, dm_win, at_max;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, if_rdata_q, dm_rdata_q;
  mem_owner_t owner_q, owner_d;
  logic squash_q;

  assign if_req = |i_if_rd_en;
  assign dm_wr  = |i_dm_wr_en;
  assign dm_req = dm_wr | (|i_dm_rd_en);

  // Grants are qualified by rst_n so every output reads 0 while reset is held.
  assign if_win = rst_n & if_req & (~dm_req | at_max);
  assign dm_win = rst_n & dm_req & ~if_win;

  assign o_if_gnt   = if_win;
  assign o_dm_gnt   = dm_win;
  assign o_if_stall = rst_n & if_req & ~if_win;

  arb_streak_counter #(.MAX(MAX_DM_STREAK)) u_streak (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (dm_win & if_req),
    .clr    (if_win | ~if_req),
    .at_max (at_max)
  );

  // IF never writes, so wdata only follows DM grants.
  always_comb begin
    o_mem_addr  = addr_q;
    o_mem_wdata = wdata_q;
    o_mem_rd_en = '0;
    o_mem_wr_en = '0;
    if (if_win) begin
      o_mem_addr  = i_if_addr;
      o_mem_rd_en = i_if_rd_en;
    end else if (dm_win) begin
      o_mem_addr  = i_dm_addr;
      o_mem_wdata = i_dm_wdata;
      if (dm_wr) o_mem_wr_en = i_dm_wr_en;
      else       o_mem_rd_en = i_dm_rd_en;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_win)               owner_d = OWN_IF;
    else if (dm_win && !dm_wr) owner_d = OWN_DM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      squash_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      owner_q  <= owner_d;
      squash_q <= if_win & i_if_flush;
      addr_q   <= o_mem_addr;
      wdata_q  <= o_mem_wdata;
    end
  end

  // A flush in either the grant cycle or the response cycle kills the fetch.
  assign o_if_rvalid = (owner_q == OWN_IF) & ~squash_q & ~i_if_flush;
  assign o_dm_rvalid = (owner_q == OWN_DM);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : if_rdata_q;
  assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : dm_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (o_if_rvalid) if_rdata_q <= i_mem_rdata;
      if (o_dm_rvalid) dm_rdata_q <= i_mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, directed scenarios and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BE = 4, MAXS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [BE-1:0] if_rd, dm_rd, dm_wr, mem_rd_en, mem_wr_en;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic if_flush, if_gnt, if_rvalid, if_stall, dm_gnt, dm_rvalid;

  int checks = 0, errors = 0;
  logic [DW-1:0] mem [0:1023];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DM_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_rd_en(if_rd), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata), .o_if_stall(if_stall),
    .i_dm_rd_en(dm_rd), .i_dm_wr_en(dm_wr), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
    .o_mem_addr(mem_addr), .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(int i);
    return 32'hA5000000 | (32'(i) * 32'h0000_0107);
  endfunction

  // Single-port synchronous RAM with byte writes and 1-cycle read latency.
  always @(posedge clk) begin
    if (|mem_wr_en)
      for (int b = 0; b < BE; b++)
        if (mem_wr_en[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (|mem_rd_en) mem_rdata <= mem[mem_addr[11:2]];
  end

  task automatic set_idle();
    if_rd = '0; if_addr = '0; if_flush = 1'b0;
    dm_rd = '0; dm_wr = '0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    @(negedge clk); #1;
    checks++;
    if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_stall, if_rdata, dm_rdata,
         mem_addr, mem_rd_en, mem_wr_en, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset.outputs got gnt=%b%b rv=%b%b stall=%b addr=%h rd=%h wr=%h exp all 0",
               if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_stall, mem_addr, mem_rd_en, mem_wr_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_if_stream();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      if (i < 3) begin if_rd = 4'hF; if_addr = 32'(i * 4); end
      #1;
      if (i < 3) begin
        checks++;
        if (if_gnt !== 1'b1 || if_stall !== 1'b0 || mem_addr !== 32'(i * 4)) begin
          errors++;
          $display("FAIL if_stream.gnt[%0d] got gnt=%b stall=%b addr=%h exp 1 0 %h",
                   i, if_gnt, if_stall, mem_addr, 32'(i * 4));
        end
      end
      if (i > 0) begin
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== init_word(i - 1)) begin
          errors++;
          $display("FAIL if_stream.rdata[%0d] got rv=%b %h exp 1 %h", i, if_rvalid, if_rdata, init_word(i - 1));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    set_idle();
    if_rd = 4'hF; if_addr = 32'h10; dm_rd = 4'hF; dm_addr = 32'h100;
    #1;
    checks++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || if_stall !== 1'b1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL contention.dm_wins got dm=%b if=%b stall=%b addr=%h exp 1 0 1 100",
               dm_gnt, if_gnt, if_stall, mem_addr);
    end
    @(negedge clk);
    dm_rd = '0;
    #1;
    checks++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== init_word(32'h40) || if_gnt !== 1'b1 || if_stall !== 1'b0) begin
      errors++;
      $display("FAIL contention.dm_resp got rv=%b %h if_gnt=%b stall=%b exp 1 %h 1 0",
               dm_rvalid, dm_rdata, if_gnt, if_stall, init_word(32'h40));
    end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== init_word(4)) begin
      errors++;
      $display("FAIL contention.if_resp got rv=%b %h exp 1 %h", if_rvalid, if_rdata, init_word(4));
    end
    @(negedge clk);
  endtask

  task automatic test_streak();
    set_idle();
    if_rd = 4'hF; if_addr = 32'h20; dm_rd = 4'hF; dm_addr = 32'h104;
    for (int k = 0; k < 15; k++) begin
      #1;
      checks++;
      if (if_gnt !== (k % 5 == 4) || dm_gnt !== (k % 5 != 4)) begin
        errors++;
        $display("FAIL streak.slot[%0d] got if=%b dm=%b exp if=%b", k, if_gnt, dm_gnt, (k % 5 == 4));
      end
      @(negedge clk);
    end
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_partial_write();
    logic [DW-1:0] orig, expw;
    orig = init_word(32'h80);
    expw = {orig[31:16], 16'hBEEF};
    set_idle();
    dm_wr = 4'b0011; dm_rd = 4'hF; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (dm_gnt !== 1'b1 || mem_wr_en !== 4'b0011 || mem_rd_en !== 4'b0000 || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write.grant got gnt=%b wr=%b rd=%b wdata=%h exp 1 0011 0000 deadbeef",
               dm_gnt, mem_wr_en, mem_rd_en, mem_wdata);
    end
    @(negedge clk);
    dm_wr = '0; dm_rd = 4'hF;
    #1;
    checks++;
    if (dm_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write.no_rvalid got %b exp 0", dm_rvalid);
    end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== expw) begin
      errors++;
      $display("FAIL write.readback got rv=%b %h exp 1 %h", dm_rvalid, dm_rdata, expw);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    set_idle();
    if_rd = 4'hF; if_addr = 32'h40; if_flush = 1'b1;
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush.gnt_a got %b exp 1", if_gnt); end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (if_rvalid !== 1'b0) begin errors++; $display("FAIL flush.grant_cycle got rv=%b exp 0", if_rvalid); end
    @(negedge clk);
    if_rd = 4'hF; if_addr = 32'h40;
    @(negedge clk);
    set_idle();
    if_flush = 1'b1;
    #1;
    checks++;
    if (if_rvalid !== 1'b0) begin errors++; $display("FAIL flush.resp_cycle got rv=%b exp 0", if_rvalid); end
    @(negedge clk);
    set_idle();
    if_rd = 4'hF; if_addr = 32'h80;
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== init_word(32'h20)) begin
      errors++;
      $display("FAIL flush.recover got rv=%b %h exp 1 %h", if_rvalid, if_rdata, init_word(32'h20));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    set_idle();
    dm_rd = 4'hF; dm_addr = 32'h108;
    #1;
    checks++;
    if (dm_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid.gnt got %b exp 1", dm_gnt); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_stall, if_rdata, dm_rdata,
         mem_addr, mem_rd_en, mem_wr_en, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid.outputs got dm_gnt=%b dm_rv=%b dm_rdata=%h addr=%h rd=%h exp all 0",
               dm_gnt, dm_rvalid, dm_rdata, mem_addr, mem_rd_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (dm_rvalid !== 1'b0 || dm_rdata !== '0) begin
        errors++;
        $display("FAIL rst_mid.after[%0d] got rv=%b %h exp 0 0", i, dm_rvalid, dm_rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int streak = 0;
    bit pend_v = 0, pend_if = 0, pend_fl = 0;
    logic [DW-1:0] pend_d = '0, last_if = '0, last_dm = '0, ewd;
    logic [AW-1:0] last_addr = '0, eaddr;
    logic [BE-1:0] erd, ewr;
    bit ireq, dreq, dwr, eif, edm, eifv, edmv;
    int r;
    rst_n = 1'b0; set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if_rd    = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 15)) : 4'h0;
      if_addr  = 32'($urandom_range(0, 15)) << 2;
      r        = $urandom_range(0, 9);
      dm_wr    = (r < 2) ? 4'($urandom_range(1, 15)) : 4'h0;
      dm_rd    = (r < 7) ? 4'($urandom_range(1, 15)) : 4'h0;
      dm_addr  = 32'($urandom_range(0, 15)) << 2;
      dm_wdata = $urandom;
      if_flush = ($urandom_range(0, 9) == 0);
      #1;
      ireq = |if_rd; dwr = |dm_wr; dreq = dwr || (|dm_rd);
      eif  = ireq && (!dreq || streak == MAXS);
      edm  = dreq && !eif;
      eaddr = eif ? if_addr : edm ? dm_addr : last_addr;
      erd   = eif ? if_rd : (edm && !dwr) ? dm_rd : '0;
      ewr   = (edm && dwr) ? dm_wr : '0;
      ewd   = dm_wdata;
      eifv  = pend_v && pend_if && !pend_fl && !if_flush;
      edmv  = pend_v && !pend_if;
      if (eifv) last_if = pend_d;
      if (edmv) last_dm = pend_d;
      checks++;
      if (if_gnt !== eif || dm_gnt !== edm || if_stall !== (ireq && !eif)) begin
        errors++;
        $display("FAIL rand.arb[%0d] got if=%b dm=%b stall=%b exp %b %b %b",
                 c, if_gnt, dm_gnt, if_stall, eif, edm, ireq && !eif);
      end
      checks++;
      if (mem_addr !== eaddr || mem_rd_en !== erd || mem_wr_en !== ewr ||
          (edm && dwr && mem_wdata !== ewd)) begin
        errors++;
        $display("FAIL rand.mem[%0d] got addr=%h rd=%h wr=%h wd=%h exp %h %h %h %h",
                 c, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, eaddr, erd, ewr, ewd);
      end
      checks++;
      if (if_rvalid !== eifv || if_rdata !== last_if || dm_rvalid !== edmv || dm_rdata !== last_dm) begin
        errors++;
        $display("FAIL rand.resp[%0d] got if=%b/%h dm=%b/%h exp %b/%h %b/%h",
                 c, if_rvalid, if_rdata, dm_rvalid, dm_rdata, eifv, last_if, edmv, last_dm);
      end
      last_addr = eaddr;
      if (eif || !ireq)  streak = 0;
      else if (edm)      streak = (streak < MAXS) ? streak + 1 : MAXS;
      pend_v  = eif || (edm && !dwr);
      pend_if = eif;
      pend_fl = eif && if_flush;
      pend_d  = mem[eaddr[11:2]];
      @(negedge clk);
    end
    set_idle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    test_reset();
    test_if_stream();
    test_contention();
    test_streak();
    test_partial_write();
    test_flush();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
